// File: rtl/d_mem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package d_mem_arbiter_pkg;

  typedef enum logic {IDLE, WAIT} arb_state_e;

  typedef enum logic {PORT_C, PORT_D} port_id_e;

  localparam logic [31:0] MMIO_ADDR_DEF = 32'h0000_00FC;

  // Wide enough for MEM_LAT-1 with MEM_LAT up to 7.
  localparam int unsigned LAT_W = $clog2(8);

endpackage

// File: rtl/d_mem_arbiter_if.sv
// Core, debug and memory-side signals of the data-memory arbiter.
interface d_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;
  logic              c_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  // Arbiter side.
  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata, c_stall,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  // Requester and memory side.
  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata, c_stall,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );

endinterface

// File: rtl/d_mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie, the port that did not win last time.
module rr_arb2
  import d_mem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_id_e   rr_last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (req_i == 2'b11) begin
      gnt_o = (rr_last_i == PORT_D) ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/d_mem_arbiter.sv
// Shares the single-port data memory between the MEM stage (C) and the debug port (D),
// sequences reads over MEM_LAT cycles and owns the memory-mapped output register.
module d_mem_arbiter
  import d_mem_arbiter_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       MEM_LAT   = 1,
  parameter logic [ADDR_W-1:0] MMIO_ADDR = ADDR_W'(MMIO_ADDR_DEF)
) (
  input  logic              clk_t,
  input  logic              rst_t,
  d_mem_arbiter_if.slave    bus,
  output logic [DATA_W-1:0] mem_map_io_t
);

  arb_state_e        state_q, state_d;
  port_id_e          rr_last_q, rr_last_d;
  port_id_e          owner_q, owner_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              rd_mmio_q, rd_mmio_d;
  logic              c_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0] c_rdata_q, d_rdata_q;
  logic [DATA_W-1:0] mmio_q;

  logic [1:0]        arb_req, arb_gnt;
  logic              win_valid, win_d, win_we, win_mmio;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              cap;
  logic [DATA_W-1:0] cap_data;

  // Requests are only visible to the picker while idle, so WAIT never grants.
  assign arb_req = {bus.d_req, bus.c_req} & {2{state_q == IDLE}};

  rr_arb2 u_rr_arb2 (
    .req_i     (arb_req),
    .rr_last_i (rr_last_q),
    .gnt_o     (arb_gnt)
  );

  assign win_valid = |arb_gnt;
  assign win_d     = arb_gnt[1];
  assign win_we    = win_d ? bus.d_we    : bus.c_we;
  assign win_addr  = win_d ? bus.d_addr  : bus.c_addr;
  assign win_wdata = win_d ? bus.d_wdata : bus.c_wdata;
  assign win_mmio  = (win_addr == MMIO_ADDR);

  assign cap      = (state_q == WAIT) && (lat_cnt_q == '0);
  assign cap_data = rd_mmio_q ? mmio_q : bus.m_rdata;

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    owner_d   = owner_q;
    lat_cnt_d = lat_cnt_q;
    rd_mmio_d = rd_mmio_q;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          rr_last_d = port_id_e'(win_d);
          if (!win_we) begin
            state_d   = WAIT;
            owner_d   = port_id_e'(win_d);
            lat_cnt_d = LAT_W'(MEM_LAT - 1);
            rd_mmio_d = win_mmio;
          end
        end
      end
      WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_t) begin
    if (rst_t) begin
      state_q    <= IDLE;
      rr_last_q  <= PORT_D;
      owner_q    <= PORT_C;
      lat_cnt_q  <= '0;
      rd_mmio_q  <= 1'b0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
      mmio_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      owner_q    <= owner_d;
      lat_cnt_q  <= lat_cnt_d;
      rd_mmio_q  <= rd_mmio_d;
      c_rvalid_q <= cap && (owner_q == PORT_C);
      d_rvalid_q <= cap && (owner_q == PORT_D);
      if (cap && (owner_q == PORT_C)) c_rdata_q <= cap_data;
      if (cap && (owner_q == PORT_D)) d_rdata_q <= cap_data;
      if (win_valid && win_we && win_mmio) mmio_q <= win_wdata;
    end
  end

  assign bus.c_gnt    = arb_gnt[0];
  assign bus.d_gnt    = arb_gnt[1];
  assign bus.c_rvalid = c_rvalid_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.c_rdata  = c_rdata_q;
  assign bus.d_rdata  = d_rdata_q;

  assign bus.m_en    = win_valid && !win_mmio;
  assign bus.m_we    = win_valid && !win_mmio && win_we;
  assign bus.m_addr  = win_addr;
  assign bus.m_wdata = win_wdata;

  // A core read stalls from its grant cycle until the cycle its rvalid pulses.
  assign bus.c_stall = (bus.c_req && !arb_gnt[0])
                     || (arb_gnt[0] && !bus.c_we)
                     || ((state_q == WAIT) && (owner_q == PORT_C));

  assign mem_map_io_t = mmio_q;

  c_hold_stable : assert property (@(posedge clk_t) disable iff (rst_t)
    (bus.c_req && !bus.c_gnt) |=>
      (!bus.c_req || ($stable(bus.c_we) && $stable(bus.c_addr) && $stable(bus.c_wdata))));

  d_hold_stable : assert property (@(posedge clk_t) disable iff (rst_t)
    (bus.d_req && !bus.d_gnt) |=>
      (!bus.d_req || ($stable(bus.d_we) && $stable(bus.d_addr) && $stable(bus.d_wdata))));

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Directed bench for d_mem_arbiter: cycle table for MEM_LAT=1 plus round-robin and MEM_LAT=3 reset sequences.
module tb_d_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst1, rst3;
  logic [31:0] mmio1, mmio3;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  d_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  d_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

  d_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MMIO_ADDR(32'h0000_00FC)) dut1 (
    .clk_t(clk), .rst_t(rst1), .bus(b1), .mem_map_io_t(mmio1));

  d_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MMIO_ADDR(32'h0000_00FC)) dut3 (
    .clk_t(clk), .rst_t(rst3), .bus(b3), .mem_map_io_t(mmio3));

  // Memory model for dut1: one-cycle read latency; unwritten words hold a fixed pattern.
  logic [31:0] mem [0:63];
  logic [63:0] wr_v = '0;

  function automatic logic [31:0] dflt(input logic [5:0] idx);
    return (idx == 6'd4) ? 32'hDEAD_BEEF : {16'hA5A5, 8'h00, 2'b00, idx};
  endfunction

  always @(posedge clk) begin
    if (b1.m_en && b1.m_we) begin
      mem[b1.m_addr[7:2]]   <= b1.m_wdata;
      wr_v[b1.m_addr[7:2]]  <= 1'b1;
    end
    if (b1.m_en && !b1.m_we)
      b1.m_rdata <= wr_v[b1.m_addr[7:2]] ? mem[b1.m_addr[7:2]] : dflt(b1.m_addr[7:2]);
  end

  assign b3.m_rdata = 32'hCAFE_F00D;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  c_ctl;   // {req, we}
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [1:0]  d_ctl;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [6:0]  e_flags; // {c_gnt, d_gnt, m_en, m_we, c_stall, c_rvalid, d_rvalid}
    logic [31:0] e_mmio;
    logic [1:0]  rsel;    // 1: check c_rdata, 2: check d_rdata
    logic [31:0] e_rdata;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  task automatic pair(input bit d_first, input string tag);
    int cg = -1, dg = -1, cv = -1, dv = -1;
    logic [31:0] cr = '0, dr = '0;
    logic drop_c, drop_d;
    b1.c_req = 1'b1; b1.c_we = 1'b0; b1.c_addr = 32'h10;
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h24;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      drop_c = b1.c_gnt;
      drop_d = b1.d_gnt;
      if (b1.c_gnt && cg < 0) cg = cyc;
      if (b1.d_gnt && dg < 0) dg = cyc;
      if (b1.c_rvalid && cv < 0) begin cv = cyc; cr = b1.c_rdata; end
      if (b1.d_rvalid && dv < 0) begin dv = cyc; dr = b1.d_rdata; end
      @(posedge clk); #1;
      if (drop_c) b1.c_req = 1'b0;
      if (drop_d) b1.d_req = 1'b0;
    end
    chk({tag, " c_gnt cycle"},    cg, d_first ? 32'd2 : 32'd0);
    chk({tag, " c_rvalid cycle"}, cv, d_first ? 32'd4 : 32'd2);
    chk({tag, " d_gnt cycle"},    dg, d_first ? 32'd0 : 32'd2);
    chk({tag, " d_rvalid cycle"}, dv, d_first ? 32'd2 : 32'd4);
    chk({tag, " c_rdata"}, cr, 32'hDEAD_BEEF);
    chk({tag, " d_rdata"}, dr, 32'h0000_0002);
  endtask

  initial begin
    int n;
    int cv;
    logic [31:0] rd;

    tbl[0]  = '{2'b10, 32'h10, 32'h0, 2'b00, 32'h0,  32'h0, 7'b1010100, 32'h00, 2'd0, 32'h0};
    tbl[1]  = '{2'b00, 32'h0,  32'h0, 2'b00, 32'h0,  32'h0, 7'b0000100, 32'h00, 2'd0, 32'h0};
    tbl[2]  = '{2'b00, 32'h0,  32'h0, 2'b00, 32'h0,  32'h0, 7'b0000010, 32'h00, 2'd1, 32'hDEAD_BEEF};
    tbl[3]  = '{2'b11, 32'hFC, 32'h55, 2'b00, 32'h0, 32'h0, 7'b1000000, 32'h00, 2'd0, 32'h0};
    tbl[4]  = '{2'b00, 32'h0,  32'h0, 2'b10, 32'hFC, 32'h0, 7'b0100000, 32'h55, 2'd0, 32'h0};
    tbl[5]  = '{2'b00, 32'h0,  32'h0, 2'b00, 32'h0,  32'h0, 7'b0000000, 32'h55, 2'd0, 32'h0};
    tbl[6]  = '{2'b00, 32'h0,  32'h0, 2'b00, 32'h0,  32'h0, 7'b0000001, 32'h55, 2'd2, 32'h55};
    tbl[7]  = '{2'b11, 32'h20, 32'h1, 2'b00, 32'h0,  32'h0, 7'b1011000, 32'h55, 2'd0, 32'h0};
    tbl[8]  = '{2'b11, 32'h24, 32'h2, 2'b00, 32'h0,  32'h0, 7'b1011000, 32'h55, 2'd0, 32'h0};
    tbl[9]  = '{2'b11, 32'h28, 32'h3, 2'b00, 32'h0,  32'h0, 7'b1011000, 32'h55, 2'd0, 32'h0};
    tbl[10] = '{2'b00, 32'h0,  32'h0, 2'b00, 32'h0,  32'h0, 7'b0000000, 32'h55, 2'd0, 32'h0};
    tbl[11] = '{2'b10, 32'h20, 32'h0, 2'b00, 32'h0,  32'h0, 7'b1010100, 32'h55, 2'd0, 32'h0};
    tbl[12] = '{2'b00, 32'h0,  32'h0, 2'b10, 32'h30, 32'h0, 7'b0000100, 32'h55, 2'd0, 32'h0};
    tbl[13] = '{2'b00, 32'h0,  32'h0, 2'b00, 32'h0,  32'h0, 7'b0000010, 32'h55, 2'd1, 32'h1};
    tbl[14] = '{2'b00, 32'h0,  32'h0, 2'b00, 32'h0,  32'h0, 7'b0000000, 32'h55, 2'd0, 32'h0};

    b1.c_req = 1'b0; b1.c_we = 1'b0; b1.c_addr = '0; b1.c_wdata = '0;
    b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
    b3.c_req = 1'b0; b3.c_we = 1'b0; b3.c_addr = '0; b3.c_wdata = '0;
    b3.d_req = 1'b0; b3.d_we = 1'b0; b3.d_addr = '0; b3.d_wdata = '0;
    rst1 = 1'b1; rst3 = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst1 = 1'b0; rst3 = 1'b0;

    @(negedge clk);
    chkb("reset c_gnt",    b1.c_gnt,    1'b0);
    chkb("reset m_en",     b1.m_en,     1'b0);
    chkb("reset c_rvalid", b1.c_rvalid, 1'b0);
    chkb("reset d_rvalid", b1.d_rvalid, 1'b0);
    chkb("reset c_stall",  b1.c_stall,  1'b0);
    chk("reset c_rdata",   b1.c_rdata,  32'h0);
    chk("reset d_rdata",   b1.d_rdata,  32'h0);
    chk("reset mmio",      mmio1,       32'h0);
    chk("reset mmio lat3", mmio3,       32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      b1.c_req = tbl[i].c_ctl[1]; b1.c_we = tbl[i].c_ctl[0];
      b1.c_addr = tbl[i].c_addr;  b1.c_wdata = tbl[i].c_wdata;
      b1.d_req = tbl[i].d_ctl[1]; b1.d_we = tbl[i].d_ctl[0];
      b1.d_addr = tbl[i].d_addr;  b1.d_wdata = tbl[i].d_wdata;
      @(negedge clk);
      chkb($sformatf("row%0d c_gnt", i),    b1.c_gnt,    tbl[i].e_flags[6]);
      chkb($sformatf("row%0d d_gnt", i),    b1.d_gnt,    tbl[i].e_flags[5]);
      chkb($sformatf("row%0d m_en", i),     b1.m_en,     tbl[i].e_flags[4]);
      chkb($sformatf("row%0d m_we", i),     b1.m_we,     tbl[i].e_flags[3]);
      chkb($sformatf("row%0d c_stall", i),  b1.c_stall,  tbl[i].e_flags[2]);
      chkb($sformatf("row%0d c_rvalid", i), b1.c_rvalid, tbl[i].e_flags[1]);
      chkb($sformatf("row%0d d_rvalid", i), b1.d_rvalid, tbl[i].e_flags[0]);
      chk($sformatf("row%0d mem_map_io_t", i), mmio1, tbl[i].e_mmio);
      if (tbl[i].rsel == 2'd1) chk($sformatf("row%0d c_rdata", i), b1.c_rdata, tbl[i].e_rdata);
      if (tbl[i].rsel == 2'd2) chk($sformatf("row%0d d_rdata", i), b1.d_rdata, tbl[i].e_rdata);
      @(posedge clk); #1;
    end

    // Round-robin: fresh reset so C wins the first tie, then alternation.
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    pair(1'b0, "rr1");
    pair(1'b0, "rr2");
    b1.c_req = 1'b1; b1.c_we = 1'b1; b1.c_addr = 32'h2C; b1.c_wdata = 32'h7;
    @(negedge clk);
    chkb("rr core write gnt", b1.c_gnt, 1'b1);
    @(posedge clk); #1;
    b1.c_req = 1'b0; b1.c_we = 1'b0;
    pair(1'b1, "rr3");

    // MEM_LAT=3: reset during WAIT abandons the read.
    b3.c_req = 1'b1; b3.c_we = 1'b0; b3.c_addr = 32'h40;
    @(negedge clk);
    chkb("lat3 first c_gnt", b3.c_gnt, 1'b1);
    chkb("lat3 first m_en",  b3.m_en,  1'b1);
    @(posedge clk); #1;
    b3.c_req = 1'b0; rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (b3.c_rvalid) n++;
      @(posedge clk); #1;
    end
    chk("lat3 rvalid after reset", n, 32'd0);
    @(negedge clk);
    chkb("lat3 idle stall", b3.c_stall, 1'b0);
    @(posedge clk); #1;

    b3.c_req = 1'b1; b3.c_addr = 32'h44;
    cv = -1; rd = '0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (cyc == 0) chkb("lat3 regrant immediate", b3.c_gnt, 1'b1);
      if (cyc == 3) chkb("lat3 stall before rvalid", b3.c_stall, 1'b1);
      if (b3.c_rvalid && cv < 0) begin cv = cyc; rd = b3.c_rdata; end
      @(posedge clk); #1;
      if (cyc == 0) b3.c_req = 1'b0;
    end
    chk("lat3 rvalid cycle", cv, 32'd4);
    chk("lat3 c_rdata", rd, 32'hCAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
